// File: rtl/ddr2_turnaround_pkg.sv
// Shared definitions for the DDR2 turnaround monitor: violation bit indices,
// command decode and default timing minima (overridable via DDR2_TIMING_* macros).
package ddr2_turnaround_pkg;

    localparam int VIOL_WTR = 0;
    localparam int VIOL_RTW = 1;
    localparam int VIOL_WR  = 2;
    localparam int VIOL_RTP = 3;
    localparam int VIOL_MCS = 4;
    localparam int VIOL_W   = 5;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_PRE   = 2'd3
    } cmd_e;

`ifndef DDR2_TIMING_TWTR_MIN
`define DDR2_TIMING_TWTR_MIN 2
`endif
`ifndef DDR2_TIMING_TRTW_MIN
`define DDR2_TIMING_TRTW_MIN 4
`endif
`ifndef DDR2_TIMING_TWR_MIN
`define DDR2_TIMING_TWR_MIN 4
`endif
`ifndef DDR2_TIMING_TRTP_MIN
`define DDR2_TIMING_TRTP_MIN 2
`endif

    localparam int DEF_TWTR_MIN = `DDR2_TIMING_TWTR_MIN;
    localparam int DEF_TRTW_MIN = `DDR2_TIMING_TRTW_MIN;
    localparam int DEF_TWR_MIN  = `DDR2_TIMING_TWR_MIN;
    localparam int DEF_TRTP_MIN = `DDR2_TIMING_TRTP_MIN;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Only READ, WRITE and PRE matter; every other encoding (incl. A10 variants) is ignored.
    function automatic cmd_e decode_cmd(input logic ras_n, input logic cas_n, input logic we_n);
        cmd_e c;
        case ({ras_n, cas_n, we_n})
            3'b101:  c = CMD_READ;
            3'b100:  c = CMD_WRITE;
            3'b010:  c = CMD_PRE;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ddr2_turnaround_monitor_age_counter.sv
// Saturating command-age counter: age restarts at 1 on a hit and otherwise
// counts up, holding at its all-ones maximum.
module ddr2_age_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
    output logic             valid,
    output logic [CNT_W-1:0] age
);

    localparam logic [CNT_W-1:0] AGE_MAX = '1;

    logic             valid_q, valid_d;
    logic [CNT_W-1:0] age_q, age_d;

    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        if (hit) begin
            valid_d = 1'b1;
            age_d   = CNT_W'(1);
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    assign valid = valid_q;
    assign age   = age_q;

endmodule

// File: rtl/ddr2_turnaround_monitor.sv
// DDR2 pad-level tWTR/tRTW/tWR/tRTP and multi-chip-select monitor with error log.
// Define DDR2_TURNAROUND_FATAL_EN to print each violation and stop with $fatal.
module ddr2_turnaround_monitor
    import ddr2_turnaround_pkg::*;
#(
    parameter int NUM_RANKS = 1,
    parameter int NUM_BANKS = 4,
    parameter int TWTR_MIN  = DEF_TWTR_MIN,
    parameter int TRTW_MIN  = DEF_TRTW_MIN,
    parameter int TWR_MIN   = DEF_TWR_MIN,
    parameter int TRTP_MIN  = DEF_TRTP_MIN,
    parameter int CNT_W     = 6,
    parameter int ERRCNT_W  = 16,
    localparam int BA_W     = $clog2(NUM_BANKS),
    localparam int RANK_W   = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke_pad,
    input  logic [NUM_RANKS-1:0] csbar_pad,
    input  logic                 rasbar_pad,
    input  logic                 casbar_pad,
    input  logic                 webar_pad,
    input  logic [BA_W-1:0]      ba_pad,
    input  logic                 clear_err,
    output logic [VIOL_W-1:0]    viol,
    output logic [RANK_W-1:0]    viol_rank,
    output logic [BA_W-1:0]      viol_bank,
    output logic [VIOL_W-1:0]    err_sticky,
    output logic [VIOL_W-1:0]    first_viol,
    output logic [RANK_W-1:0]    first_rank,
    output logic [BA_W-1:0]      first_bank,
    output logic [ERRCNT_W-1:0]  err_count
);

    localparam int NB_TOT  = NUM_RANKS * NUM_BANKS;
    localparam int MAX_MIN = max_of4(TWTR_MIN, TRTW_MIN, TWR_MIN, TRTP_MIN);

    // A saturated age must still be >= every minimum, or old history would look like a violation.
    if (((2 ** CNT_W) - 1) < MAX_MIN) begin : g_cnt_w_too_small
        $error("ddr2_turnaround_monitor: CNT_W too small for the largest timing minimum");
    end

    localparam logic [CNT_W-1:0] TWTR_C = CNT_W'(TWTR_MIN);
    localparam logic [CNT_W-1:0] TRTW_C = CNT_W'(TRTW_MIN);
    localparam logic [CNT_W-1:0] TWR_C  = CNT_W'(TWR_MIN);
    localparam logic [CNT_W-1:0] TRTP_C = CNT_W'(TRTP_MIN);

    // Command decode
    logic [RANK_W-1:0] sel_rank;
    int                sel_count;
    logic              multi_sel;
    cmd_e              cmd;

    always_comb begin
        sel_rank  = '0;
        sel_count = 0;
        for (int i = NUM_RANKS - 1; i >= 0; i--) begin
            if (!csbar_pad[i]) begin
                sel_rank  = RANK_W'(i);
                sel_count = sel_count + 1;
            end
        end
        multi_sel = cke_pad && (sel_count > 1);
        cmd       = (cke_pad && (sel_count == 1)) ? decode_cmd(rasbar_pad, casbar_pad, webar_pad)
                                                  : CMD_NONE;
    end

    // Age counters
    logic [NUM_RANKS-1:0]            wr_rank_valid, rd_rank_valid;
    logic [NUM_RANKS-1:0][CNT_W-1:0] wr_rank_age, rd_rank_age;
    logic [NB_TOT-1:0]               wr_bank_valid, rd_bank_valid;
    logic [NB_TOT-1:0][CNT_W-1:0]    wr_bank_age, rd_bank_age;
    logic                            rd_bus_valid;
    logic [CNT_W-1:0]                rd_bus_age;

    ddr2_age_counter #(.CNT_W(CNT_W)) u_rd_bus (
        .clk   (clk),
        .reset (reset),
        .hit   (cmd == CMD_READ),
        .valid (rd_bus_valid),
        .age   (rd_bus_age)
    );

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank
            ddr2_age_counter #(.CNT_W(CNT_W)) u_wr_rank (
                .clk   (clk),
                .reset (reset),
                .hit   ((cmd == CMD_WRITE) && (sel_rank == RANK_W'(gi))),
                .valid (wr_rank_valid[gi]),
                .age   (wr_rank_age[gi])
            );
            ddr2_age_counter #(.CNT_W(CNT_W)) u_rd_rank (
                .clk   (clk),
                .reset (reset),
                .hit   ((cmd == CMD_READ) && (sel_rank == RANK_W'(gi))),
                .valid (rd_rank_valid[gi]),
                .age   (rd_rank_age[gi])
            );
            for (gj = 0; gj < NUM_BANKS; gj++) begin : g_bank
                ddr2_age_counter #(.CNT_W(CNT_W)) u_wr_bank (
                    .clk   (clk),
                    .reset (reset),
                    .hit   ((cmd == CMD_WRITE) && (sel_rank == RANK_W'(gi)) && (ba_pad == BA_W'(gj))),
                    .valid (wr_bank_valid[gi*NUM_BANKS+gj]),
                    .age   (wr_bank_age[gi*NUM_BANKS+gj])
                );
                ddr2_age_counter #(.CNT_W(CNT_W)) u_rd_bank (
                    .clk   (clk),
                    .reset (reset),
                    .hit   ((cmd == CMD_READ) && (sel_rank == RANK_W'(gi)) && (ba_pad == BA_W'(gj))),
                    .valid (rd_bank_valid[gi*NUM_BANKS+gj]),
                    .age   (rd_bank_age[gi*NUM_BANKS+gj])
                );
            end
        end
    endgenerate

    // Per-rank read history is kept for hierarchical inspection; no rule consumes it.
    logic rd_rank_unused;
    assign rd_rank_unused = ^{rd_rank_valid, rd_rank_age};

    // Select the counters addressed by the current command
    logic             cur_wr_rank_valid, cur_wr_bank_valid, cur_rd_bank_valid;
    logic [CNT_W-1:0] cur_wr_rank_age, cur_wr_bank_age, cur_rd_bank_age;

    always_comb begin
        cur_wr_rank_valid = 1'b0;
        cur_wr_rank_age   = '0;
        cur_wr_bank_valid = 1'b0;
        cur_wr_bank_age   = '0;
        cur_rd_bank_valid = 1'b0;
        cur_rd_bank_age   = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            if (RANK_W'(r) == sel_rank) begin
                cur_wr_rank_valid = wr_rank_valid[r];
                cur_wr_rank_age   = wr_rank_age[r];
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (BA_W'(b) == ba_pad) begin
                        cur_wr_bank_valid = wr_bank_valid[r*NUM_BANKS+b];
                        cur_wr_bank_age   = wr_bank_age[r*NUM_BANKS+b];
                        cur_rd_bank_valid = rd_bank_valid[r*NUM_BANKS+b];
                        cur_rd_bank_age   = rd_bank_age[r*NUM_BANKS+b];
                    end
                end
            end
        end
    end

    logic [VIOL_W-1:0] viol_d;

    always_comb begin
        viol_d           = '0;
        viol_d[VIOL_MCS] = multi_sel;
        viol_d[VIOL_WTR] = (cmd == CMD_READ)  && cur_wr_rank_valid && (cur_wr_rank_age < TWTR_C);
        viol_d[VIOL_RTW] = (cmd == CMD_WRITE) && rd_bus_valid      && (rd_bus_age < TRTW_C);
        viol_d[VIOL_WR]  = (cmd == CMD_PRE)   && cur_wr_bank_valid && (cur_wr_bank_age < TWR_C);
        viol_d[VIOL_RTP] = (cmd == CMD_PRE)   && cur_rd_bank_valid && (cur_rd_bank_age < TRTP_C);
    end

    // Output pulse and error log
    logic [VIOL_W-1:0]   viol_q, sticky_q, sticky_d, first_viol_q, first_viol_d;
    logic [RANK_W-1:0]   viol_rank_q, viol_rank_d, first_rank_q, first_rank_d;
    logic [BA_W-1:0]     viol_bank_q, viol_bank_d, first_bank_q, first_bank_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic                any_viol;

    always_comb begin
        any_viol     = |viol_d;
        viol_rank_d  = any_viol ? sel_rank : '0;
        viol_bank_d  = any_viol ? ba_pad : '0;
        sticky_d     = sticky_q;
        err_count_d  = err_count_q;
        first_viol_d = first_viol_q;
        first_rank_d = first_rank_q;
        first_bank_d = first_bank_q;
        if (any_viol) begin
            // A violation in the same cycle as clear_err restarts the log with itself.
            if (clear_err || (sticky_q == '0)) begin
                first_viol_d = viol_d;
                first_rank_d = sel_rank;
                first_bank_d = ba_pad;
            end
            if (clear_err) begin
                sticky_d    = viol_d;
                err_count_d = ERRCNT_W'(1);
            end else begin
                sticky_d = sticky_q | viol_d;
                if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            end
        end else if (clear_err) begin
            sticky_d     = '0;
            err_count_d  = '0;
            first_viol_d = '0;
            first_rank_d = '0;
            first_bank_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            viol_q       <= '0;
            viol_rank_q  <= '0;
            viol_bank_q  <= '0;
            sticky_q     <= '0;
            err_count_q  <= '0;
            first_viol_q <= '0;
            first_rank_q <= '0;
            first_bank_q <= '0;
        end else begin
            viol_q       <= viol_d;
            viol_rank_q  <= viol_rank_d;
            viol_bank_q  <= viol_bank_d;
            sticky_q     <= sticky_d;
            err_count_q  <= err_count_d;
            first_viol_q <= first_viol_d;
            first_rank_q <= first_rank_d;
            first_bank_q <= first_bank_d;
        end
    end

    assign viol       = viol_q;
    assign viol_rank  = viol_rank_q;
    assign viol_bank  = viol_bank_q;
    assign err_sticky = sticky_q;
    assign err_count  = err_count_q;
    assign first_viol = first_viol_q;
    assign first_rank = first_rank_q;
    assign first_bank = first_bank_q;

`ifdef DDR2_TURNAROUND_FATAL_EN
    always @(posedge clk) begin
        if (!reset && any_viol) begin
            if (viol_d[VIOL_WTR])
                $display("[%0t] ERROR: tWTR rank %0d bank %0d interval %0d", $time, sel_rank, ba_pad, cur_wr_rank_age);
            if (viol_d[VIOL_RTW])
                $display("[%0t] ERROR: tRTW rank %0d bank %0d interval %0d", $time, sel_rank, ba_pad, rd_bus_age);
            if (viol_d[VIOL_WR])
                $display("[%0t] ERROR: tWR rank %0d bank %0d interval %0d", $time, sel_rank, ba_pad, cur_wr_bank_age);
            if (viol_d[VIOL_RTP])
                $display("[%0t] ERROR: tRTP rank %0d bank %0d interval %0d", $time, sel_rank, ba_pad, cur_rd_bank_age);
            if (viol_d[VIOL_MCS])
                $display("[%0t] ERROR: multi-CS rank %0d bank %0d interval 0", $time, sel_rank, ba_pad);
            $fatal(1, "ddr2_turnaround_monitor: timing violation");
        end
    end
`endif

endmodule

// File: tb/tb_ddr2_turnaround_monitor.sv
// Scoreboard bench for ddr2_turnaround_monitor with two ranks: every driven cycle
// pushes its expected viol pulse; a monitor pops and compares one cycle later.
module tb_ddr2_turnaround_monitor;
    import ddr2_turnaround_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cke_pad;
    logic [1:0] csbar_pad;
    logic       rasbar_pad, casbar_pad, webar_pad;
    logic [1:0] ba_pad;
    logic       clear_err;
    logic [4:0] viol, err_sticky, first_viol;
    logic       viol_rank, first_rank;
    logic [1:0] viol_bank, first_bank;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] viol;
        logic       rank;
        logic [1:0] bank;
    } exp_t;
    exp_t sb_q[$];

    ddr2_turnaround_monitor #(.NUM_RANKS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .cke_pad    (cke_pad),
        .csbar_pad  (csbar_pad),
        .rasbar_pad (rasbar_pad),
        .casbar_pad (casbar_pad),
        .webar_pad  (webar_pad),
        .ba_pad     (ba_pad),
        .clear_err  (clear_err),
        .viol       (viol),
        .viol_rank  (viol_rank),
        .viol_bank  (viol_bank),
        .err_sticky (err_sticky),
        .first_viol (first_viol),
        .first_rank (first_rank),
        .first_bank (first_bank),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    // Pulse checker: each driven cycle's expectation is due just after the following edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (viol !== e.viol) begin
                bad++;
                $display("FAIL viol at %0t: got %b want %b", $time, viol, e.viol);
            end
            if (e.viol != 5'b0) begin
                total++;
                if (viol_rank !== e.rank || viol_bank !== e.bank) begin
                    bad++;
                    $display("FAIL viol_loc at %0t: got rank %0d bank %0d want rank %0d bank %0d",
                             $time, viol_rank, viol_bank, e.rank, e.bank);
                end
            end
        end
    end

    task automatic step(input cmd_e c, input logic [1:0] cs, input logic [1:0] ba, input logic clr,
                        input logic [4:0] ev, input logic er, input logic [1:0] eb);
        exp_t e;
        @(negedge clk);
        csbar_pad = (c == CMD_NONE) ? 2'b11 : cs;
        case (c)
            CMD_READ:  {rasbar_pad, casbar_pad, webar_pad} = 3'b101;
            CMD_WRITE: {rasbar_pad, casbar_pad, webar_pad} = 3'b100;
            CMD_PRE:   {rasbar_pad, casbar_pad, webar_pad} = 3'b010;
            default:   {rasbar_pad, casbar_pad, webar_pad} = 3'b111;
        endcase
        ba_pad    = ba;
        clear_err = clr;
        e.viol = ev;
        e.rank = er;
        e.bank = eb;
        sb_q.push_back(e);
        if (c != CMD_NONE || clr)
            $display("[%0t] %s cs=%b ba=%0d clr=%b expect viol=%b", $time, c.name(), cs, ba, clr, ev);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(CMD_NONE, 2'b11, 2'd0, 1'b0, 5'b0, 1'b0, 2'd0);
    endtask

    task automatic test_reset();
        idle(3);
        total++;
        if (err_count !== 16'd0 || err_sticky !== 5'b0 || first_viol !== 5'b0) begin
            bad++;
            $display("FAIL reset_state: count=%0d sticky=%b first=%b want 0/0/0", err_count, err_sticky, first_viol);
        end
        reset = 1'b0;
    endtask

    task automatic test_wtr();
        step(CMD_WRITE, 2'b10, 2'd0, 1'b0, 5'b0, 1'b0, 2'd0);
        step(CMD_READ,  2'b10, 2'd0, 1'b0, 5'b00001, 1'b0, 2'd0);
        idle(1);
        total++;
        if (err_count !== 16'd1 || first_viol !== 5'b00001 || first_bank !== 2'd0 || first_rank !== 1'b0) begin
            bad++;
            $display("FAIL wtr_log: count=%0d first=%b bank=%0d want 1/00001/0", err_count, first_viol, first_bank);
        end
        idle(8);
    endtask

    task automatic test_rtw();
        step(CMD_READ,  2'b10, 2'd0, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(2);
        step(CMD_WRITE, 2'b01, 2'd3, 1'b0, 5'b00010, 1'b1, 2'd3);
        step(CMD_WRITE, 2'b01, 2'd3, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(1);
        total++;
        if (err_count !== 16'd2 || err_sticky !== 5'b00011 || first_viol !== 5'b00001) begin
            bad++;
            $display("FAIL rtw_log: count=%0d sticky=%b first=%b want 2/00011/00001", err_count, err_sticky, first_viol);
        end
        idle(8);
    endtask

    task automatic test_pre();
        step(CMD_WRITE, 2'b10, 2'd2, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(1);
        step(CMD_READ,  2'b10, 2'd2, 1'b0, 5'b0, 1'b0, 2'd0);
        step(CMD_PRE,   2'b10, 2'd2, 1'b0, 5'b01100, 1'b0, 2'd2);
        idle(1);
        total++;
        if (err_count !== 16'd3 || err_sticky !== 5'b01111) begin
            bad++;
            $display("FAIL pre_log: count=%0d sticky=%b want 3/01111", err_count, err_sticky);
        end
        idle(8);
        step(CMD_WRITE, 2'b10, 2'd2, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(1);
        step(CMD_READ,  2'b10, 2'd2, 1'b0, 5'b0, 1'b0, 2'd0);
        step(CMD_PRE,   2'b10, 2'd1, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(1);
        total++;
        if (err_count !== 16'd3) begin
            bad++;
            $display("FAIL pre_other_bank: count=%0d want 3", err_count);
        end
        idle(8);
    endtask

    task automatic test_mcs();
        step(CMD_READ,  2'b00, 2'd1, 1'b0, 5'b10000, 1'b0, 2'd1);
        step(CMD_WRITE, 2'b10, 2'd0, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(1);
        total++;
        if (err_count !== 16'd4 || err_sticky !== 5'b11111) begin
            bad++;
            $display("FAIL mcs_log: count=%0d sticky=%b want 4/11111", err_count, err_sticky);
        end
        idle(8);
    endtask

    task automatic test_clear();
        step(CMD_WRITE, 2'b01, 2'd0, 1'b0, 5'b0, 1'b0, 2'd0);
        step(CMD_READ,  2'b01, 2'd0, 1'b1, 5'b00001, 1'b1, 2'd0);
        idle(1);
        total++;
        if (err_sticky !== 5'b00001 || err_count !== 16'd1 || first_viol !== 5'b00001 ||
            first_rank !== 1'b1 || first_bank !== 2'd0) begin
            bad++;
            $display("FAIL clear_vs_viol: sticky=%b count=%0d first=%b rank=%0d want 00001/1/00001/1",
                     err_sticky, err_count, first_viol, first_rank);
        end
        step(CMD_NONE, 2'b11, 2'd0, 1'b1, 5'b0, 1'b0, 2'd0);
        idle(1);
        total++;
        if (err_sticky !== 5'b0 || err_count !== 16'd0 || first_viol !== 5'b0 || first_rank !== 1'b0) begin
            bad++;
            $display("FAIL clear_only: sticky=%b count=%0d first=%b want zeros", err_sticky, err_count, first_viol);
        end
        idle(8);
    endtask

    task automatic test_reset_mid();
        step(CMD_WRITE, 2'b10, 2'd1, 1'b0, 5'b0, 1'b0, 2'd0);
        step(CMD_READ,  2'b10, 2'd1, 1'b0, 5'b00001, 1'b0, 2'd1);
        idle(8);
        step(CMD_WRITE, 2'b10, 2'd0, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(1);
        reset = 1'b1;
        step(CMD_PRE, 2'b10, 2'd0, 1'b0, 5'b0, 1'b0, 2'd0);
        reset = 1'b0;
        idle(1);
        total++;
        if (err_count !== 16'd0 || err_sticky !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid: count=%0d sticky=%b want 0/0", err_count, err_sticky);
        end
    endtask

    task automatic test_saturate();
        logic [5:0] age;
        step(CMD_WRITE, 2'b10, 2'd3, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(200);
        age = dut.wr_bank_age[3];
        total++;
        if (age !== 6'd63) begin
            bad++;
            $display("FAIL age_saturate: got %0d want 63", age);
        end
        step(CMD_PRE, 2'b10, 2'd3, 1'b0, 5'b0, 1'b0, 2'd0);
        idle(2);
        total++;
        if (err_count !== 16'd0) begin
            bad++;
            $display("FAIL sat_pre: count=%0d want 0", err_count);
        end
    endtask

    initial begin
        reset      = 1'b1;
        cke_pad    = 1'b1;
        csbar_pad  = 2'b11;
        {rasbar_pad, casbar_pad, webar_pad} = 3'b111;
        ba_pad     = 2'd0;
        clear_err  = 1'b0;
        test_reset();
        test_wtr();
        test_rtw();
        test_pre();
        test_mcs();
        test_clear();
        test_reset_mid();
        test_saturate();
        @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
